// File: rtl/seq_play_ctrl_if.sv
// Keypad-event and board-output bundle for the sequence playback controller.
// Master drives key events; slave is the controller that drives LEDs/buzzer/status.
interface seq_play_ctrl_if #(
  parameter int unsigned SEQ_W = 8
);
  logic             key_valid;
  logic [4:0]       key_code;
  logic [SEQ_W-1:0] led;
  logic             buzzer;
  logic             busy;
  logic [2:0]       state_o;
  logic [3:0]       step_cnt;

  modport master (
    output key_valid, key_code,
    input  led, buzzer, busy, state_o, step_cnt
  );

  modport slave (
    input  key_valid, key_code,
    output led, buzzer, busy, state_o, step_cnt
  );
endinterface

// File: rtl/seq_play_ctrl.sv
// Edit/confirm/playback controller for the arbitrary-sequence generator.
// Optional macro SEQ_LOOP_EN: continuous looping playback with a one-step buzzer pulse per wrap.
module seq_play_ctrl #(
  parameter int unsigned SEQ_W       = 8,
  parameter int unsigned STEP_CYCLES = 100000000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic             clk,
  input  logic             rst,
  seq_play_ctrl_if.slave   bus
);
  localparam int unsigned STEP_W = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EDIT  = 3'd1,
    S_READY = 3'd2,
    S_PLAY  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  logic [SEQ_W-1:0]   r_edit;
  logic [SEQ_W-1:0]   r_play;
  logic [CNT_W-1:0]   r_presc;
  logic [STEP_W-1:0]  r_step;
  logic               r_buzzer;
  logic               r_busy;

  logic               w_tog;
  logic               w_mute;
  logic               w_conf;
  logic               w_clr;
  logic               w_start;
  logic [2:0]         w_idx;
  logic [SEQ_W-1:0]   w_mask;
  logic               w_tick;
  logic               w_last;

  // Command decode; only strobed cycles carry a command, all other codes are ignored
  assign w_tog   = bus.key_valid && (bus.key_code >= 5'd1) && (bus.key_code <= 5'd8);
  assign w_mute  = bus.key_valid && (bus.key_code == 5'd13);
  assign w_conf  = bus.key_valid && (bus.key_code == 5'd14);
  assign w_clr   = bus.key_valid && (bus.key_code == 5'd15);
  assign w_start = bus.key_valid && (bus.key_code == 5'd16);
  assign w_idx   = 3'(bus.key_code - 5'd1);
  assign w_mask  = SEQ_W'(1) << w_idx;

  assign w_tick  = (r_state == S_PLAY) && (r_presc == CNT_W'(STEP_CYCLES - 1));
  assign w_last  = (r_step == STEP_W'(SEQ_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_edit   <= '0;
      r_play   <= '0;
      r_presc  <= '0;
      r_step   <= '0;
      r_buzzer <= 1'b0;
      r_busy   <= 1'b0;
    end else if (w_clr) begin
      // Clear beats everything, including a coincident step tick
      r_state  <= S_IDLE;
      r_edit   <= '0;
      r_play   <= '0;
      r_presc  <= '0;
      r_step   <= '0;
      r_buzzer <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_tog) begin
            r_edit  <= r_edit ^ w_mask;
            r_state <= S_EDIT;
          end
        end
        S_EDIT: begin
          if (w_tog) begin
            r_edit  <= r_edit ^ w_mask;
          end else if (w_conf) begin
            r_play  <= r_edit;
            r_state <= S_READY;
          end
        end
        S_READY: begin
          if (w_tog) begin
            r_edit  <= r_edit ^ w_mask;
            r_state <= S_EDIT;
          end else if (w_conf) begin
            r_play  <= r_edit;
          end else if (w_start) begin
            r_play  <= r_edit;
            r_presc <= '0;
            r_step  <= '0;
            r_state <= S_PLAY;
            r_busy  <= 1'b1;
          end
        end
        S_PLAY: begin
`ifdef SEQ_LOOP_EN
          if (w_mute) begin
            r_state  <= S_READY;
            r_busy   <= 1'b0;
            r_buzzer <= 1'b0;
          end else
`endif
          if (w_tick) begin
            r_presc <= '0;
            r_play  <= {r_play[SEQ_W-2:0], r_play[SEQ_W-1]};
`ifdef SEQ_LOOP_EN
            // Buzzer lasts exactly the step period that follows each wrap
            r_buzzer <= w_last;
            r_step   <= w_last ? '0 : STEP_W'(r_step + 4'd1);
`else
            r_step   <= STEP_W'(r_step + 4'd1);
            if (w_last) begin
              r_state  <= S_DONE;
              r_buzzer <= 1'b1;
              r_busy   <= 1'b0;
            end
`endif
          end else begin
            r_presc <= CNT_W'(r_presc + 1'b1);
          end
        end
        S_DONE: begin
          if (w_mute) begin
            r_buzzer <= 1'b0;
            r_state  <= S_READY;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.led      = r_play;
  assign bus.buzzer   = r_buzzer;
  assign bus.busy     = r_busy;
  assign bus.state_o  = r_state;
  assign bus.step_cnt = r_step;

endmodule

// File: tb/tb_seq_play_ctrl.sv
// Scoreboard bench for seq_play_ctrl (STEP_CYCLES=10, SEQ_W=8); honours SEQ_LOOP_EN.
module tb_seq_play_ctrl;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  typedef struct packed {
    logic [7:0] led;
    logic [3:0] step;
    logic [2:0] st;
    logic       buz;
    logic       busy;
  } snap_t;

  typedef struct {
    string name;
    int    key;
    int    cyc;
    snap_t s;
  } exp_t;

  exp_t q[$];

  seq_play_ctrl_if #(.SEQ_W(8)) bus();

  seq_play_ctrl #(.SEQ_W(8), .STEP_CYCLES(10), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t mk(logic [7:0] led, int step, int st, logic buz, logic busy);
    snap_t s;
    s.led = led; s.step = 4'(step); s.st = 3'(st); s.buz = buz; s.busy = busy;
    return s;
  endfunction

  function automatic snap_t obs();
    return mk(bus.led, int'(bus.step_cnt), int'(bus.state_o), bus.buzzer, bus.busy);
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] v, int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // Expected outputs k cycles after the start strobe edge
  function automatic snap_t exp_play(logic [7:0] p, int k);
    int t;
    t = k / 10;
`ifdef SEQ_LOOP_EN
    return mk(rotl(p, t % 8), t % 8, 3, (t >= 8) && (t % 8 == 0), 1'b1);
`else
    if (t >= 8) return mk(p, 8, 4, 1'b1, 1'b0);
    return mk(rotl(p, t), t, 3, 1'b0, 1'b1);
`endif
  endfunction

  function automatic exp_t ent(string name, int key, snap_t s);
    exp_t e;
    e.name = name; e.key = key; e.cyc = 0; e.s = s;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 5'd0;
    q.push_back(ent("reset_held", 0, mk(8'h00, 0, 0, 1'b0, 1'b0)));
    q.push_back(ent("reset_released", 0, mk(8'h00, 0, 0, 1'b0, 1'b0)));
    repeat (2) @(posedge clk);
    #1;
    e = q.pop_front();
    n_vec++;
    if (obs() !== e.s) begin
      n_err++;
      $display("FAIL %s: got {led,step,st,buz,busy}=%h want %h", e.name, obs(), e.s);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    e = q.pop_front();
    n_vec++;
    if (obs() !== e.s) begin
      n_err++;
      $display("FAIL %s: got {led,step,st,buz,busy}=%h want %h", e.name, obs(), e.s);
    end
  endtask

  task automatic test_edit_confirm();
    exp_t e;
    q.push_back(ent("edit_k1", 1, mk(8'h00, 0, 1, 1'b0, 1'b0)));
    q.push_back(ent("edit_k3", 3, mk(8'h00, 0, 1, 1'b0, 1'b0)));
    q.push_back(ent("edit_k8", 8, mk(8'h00, 0, 1, 1'b0, 1'b0)));
    q.push_back(ent("confirm_85", 14, mk(8'h85, 0, 2, 1'b0, 1'b0)));
    q.push_back(ent("ready_hold", 0, mk(8'h85, 0, 2, 1'b0, 1'b0)));
    q.push_back(ent("retoggle_k3", 3, mk(8'h85, 0, 1, 1'b0, 1'b0)));
    q.push_back(ent("confirm_81", 14, mk(8'h81, 0, 2, 1'b0, 1'b0)));
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.key > 0) begin bus.key_valid = 1'b1; bus.key_code = 5'(e.key); end
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
      n_vec++;
      if (obs() !== e.s) begin
        n_err++;
        $display("FAIL %s: got {led,step,st,buz,busy}=%h want %h", e.name, obs(), e.s);
      end
    end
  endtask

  task automatic test_ignored_codes();
    exp_t e;
    int codes[5] = '{9, 10, 12, 17, 13};
    foreach (codes[i])
      q.push_back(ent($sformatf("ignore_k%0d", codes[i]), codes[i], mk(8'h81, 0, 2, 1'b0, 1'b0)));
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.key > 0) begin bus.key_valid = 1'b1; bus.key_code = 5'(e.key); end
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
      n_vec++;
      if (obs() !== e.s) begin
        n_err++;
        $display("FAIL %s: got {led,step,st,buz,busy}=%h want %h", e.name, obs(), e.s);
      end
    end
  endtask

  // Start from READY with edit pattern p; stray keys in PLAY must not disturb timing
  task automatic test_playback(logic [7:0] p, string tag);
    exp_t e;
    int   key;
    for (int k = 0; k <= 90; k++) begin
      if (k == 0 || k % 10 == 0 || k % 10 == 9) begin
        e.name = $sformatf("%s_c%0d", tag, k);
        e.key  = 0;
        e.cyc  = k;
        e.s    = exp_play(p, k);
        q.push_back(e);
      end
    end
    for (int k = 0; k <= 90; k++) begin
      key = 0;
      if (k == 0 || k == 25) key = 16;
      if (k == 33) key = 14;
      if (k == 41) key = 5;
`ifndef SEQ_LOOP_EN
      if (k == 47) key = 13;
`endif
      if (key > 0) begin bus.key_valid = 1'b1; bus.key_code = 5'(key); end
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
      if (q.size() > 0 && q[0].cyc == k) begin
        e = q.pop_front();
        n_vec++;
        if (obs() !== e.s) begin
          n_err++;
          $display("FAIL %s: got {led,step,st,buz,busy}=%h want %h", e.name, obs(), e.s);
        end
      end
    end
  endtask

  task automatic test_mute_replay();
    exp_t e;
`ifdef SEQ_LOOP_EN
    q.push_back(ent("mute_play", 13, mk(8'h03, 1, 2, 1'b0, 1'b0)));
`else
    q.push_back(ent("mute_done", 13, mk(8'h81, 8, 2, 1'b0, 1'b0)));
`endif
    q.push_back(ent("mute_hold", 0, q[0].s));
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.key > 0) begin bus.key_valid = 1'b1; bus.key_code = 5'(e.key); end
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
      n_vec++;
      if (obs() !== e.s) begin
        n_err++;
        $display("FAIL %s: got {led,step,st,buz,busy}=%h want %h", e.name, obs(), e.s);
      end
    end
    test_playback(8'h81, "replay");
  endtask

  task automatic test_clear_on_tick();
    exp_t  e;
    snap_t z;
    z = mk(8'h00, 0, 0, 1'b0, 1'b0);
    q.push_back(ent("clr_any", 15, z));
    q.push_back(ent("clr_k2", 2, mk(8'h00, 0, 1, 1'b0, 1'b0)));
    q.push_back(ent("clr_conf", 14, mk(8'h02, 0, 2, 1'b0, 1'b0)));
    q.push_back(ent("clr_start", 16, mk(8'h02, 0, 3, 1'b0, 1'b1)));
    for (int k = 1; k <= 9; k++)
      q.push_back(ent($sformatf("clr_wait%0d", k), 0, mk(8'h02, 0, 3, 1'b0, 1'b1)));
    q.push_back(ent("clr_on_tick", 15, z));
    q.push_back(ent("clr_idle_k14", 14, z));
    q.push_back(ent("clr_idle_k16", 16, z));
    q.push_back(ent("clr_edit_k2", 2, mk(8'h00, 0, 1, 1'b0, 1'b0)));
    q.push_back(ent("clr_edit_cleared", 14, mk(8'h02, 0, 2, 1'b0, 1'b0)));
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.key > 0) begin bus.key_valid = 1'b1; bus.key_code = 5'(e.key); end
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
      n_vec++;
      if (obs() !== e.s) begin
        n_err++;
        $display("FAIL %s: got {led,step,st,buz,busy}=%h want %h", e.name, obs(), e.s);
      end
    end
  endtask

  task automatic test_zero_pattern();
    exp_t e;
    q.push_back(ent("zero_clr", 15, mk(8'h00, 0, 0, 1'b0, 1'b0)));
    q.push_back(ent("zero_k1a", 1, mk(8'h00, 0, 1, 1'b0, 1'b0)));
    q.push_back(ent("zero_k1b", 1, mk(8'h00, 0, 1, 1'b0, 1'b0)));
    q.push_back(ent("zero_conf", 14, mk(8'h00, 0, 2, 1'b0, 1'b0)));
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.key > 0) begin bus.key_valid = 1'b1; bus.key_code = 5'(e.key); end
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
      n_vec++;
      if (obs() !== e.s) begin
        n_err++;
        $display("FAIL %s: got {led,step,st,buz,busy}=%h want %h", e.name, obs(), e.s);
      end
    end
    test_playback(8'h00, "zero");
  endtask

  task automatic test_reset_mid_play();
    exp_t e;
    q.push_back(ent("mid_clr", 15, mk(8'h00, 0, 0, 1'b0, 1'b0)));
    q.push_back(ent("mid_k4", 4, mk(8'h00, 0, 1, 1'b0, 1'b0)));
    q.push_back(ent("mid_conf", 14, mk(8'h08, 0, 2, 1'b0, 1'b0)));
    q.push_back(ent("mid_start", 16, mk(8'h08, 0, 3, 1'b0, 1'b1)));
    for (int k = 1; k <= 15; k++)
      if (k == 9 || k == 10 || k == 15)
        q.push_back(ent($sformatf("mid_c%0d", k), 0,
                        (k < 10) ? mk(8'h08, 0, 3, 1'b0, 1'b1) : mk(8'h10, 1, 3, 1'b0, 1'b1)));
      else
        q.push_back(ent("", -1, mk(8'h00, 0, 0, 1'b0, 1'b0)));
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.key > 0) begin bus.key_valid = 1'b1; bus.key_code = 5'(e.key); end
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
      if (e.key >= 0) begin
        n_vec++;
        if (obs() !== e.s) begin
          n_err++;
          $display("FAIL %s: got {led,step,st,buz,busy}=%h want %h", e.name, obs(), e.s);
        end
      end
    end
    // Pulse reset between clock edges; outputs must drop without waiting for clk
    q.push_back(ent("mid_async_rst", 0, mk(8'h00, 0, 0, 1'b0, 1'b0)));
    q.push_back(ent("mid_after_rst", 0, mk(8'h00, 0, 0, 1'b0, 1'b0)));
    q.push_back(ent("mid_post_k4", 4, mk(8'h00, 0, 1, 1'b0, 1'b0)));
    #2;
    rst = 1'b1;
    #1;
    e = q.pop_front();
    n_vec++;
    if (obs() !== e.s) begin
      n_err++;
      $display("FAIL %s: got {led,step,st,buz,busy}=%h want %h", e.name, obs(), e.s);
    end
    #1;
    rst = 1'b0;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.key > 0) begin bus.key_valid = 1'b1; bus.key_code = 5'(e.key); end
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
      n_vec++;
      if (obs() !== e.s) begin
        n_err++;
        $display("FAIL %s: got {led,step,st,buz,busy}=%h want %h", e.name, obs(), e.s);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_edit_confirm();
    test_ignored_codes();
    test_playback(8'h81, "play81");
    test_mute_replay();
    test_clear_on_tick();
    test_zero_pattern();
    test_reset_mid_play();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
